// File: rtl/tx_chunk_pkg.sv
// Shared types and constants for the TX chunk framer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tx_chunk_pkg;

  // Framer FSM state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  // Chunk type byte emitted by the virtual-display producer.
  localparam logic [7:0] CHUNK_TYPE_DISPLAY = 8'h06;

  // Starting value of the XOR checksum accumulator.
  localparam logic [7:0] CSUM_SEED = 8'h00;

  // One checksum accumulation step.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/tx_chunk_framer.sv
// Serialises one chunk (type byte, payload bytes, optional XOR checksum) onto a UART byte stream, then pulses an ack to the producer.
// Latency: first byte one cycle after chunk_valid is seen in IDLE; one byte per accepted cycle; ack the cycle after the last byte.
// Backpressure: tx_ready low holds tx_data/tx_valid stable and stretches the frame by exactly one cycle per stalled cycle.
//
// Ports:
//   CLK, RST_N          - clock (rising edge), asynchronous active-low reset
//   chunk_valid         - producer level request, held until chunk_ack
//   chunk_type          - type byte, sent first
//   chunk_bytes         - payload, byte 0 in bits [7:0], sent after type
//   chunk_ack           - one-cycle acknowledge pulse to the producer
//   tx_data/tx_valid    - byte offered to the UART
//   tx_ready            - UART takes the byte when tx_valid && tx_ready
//   busy                - high whenever the framer is not IDLE
//
// Build option: define TX_CHUNK_CHECKSUM_EN to append the XOR checksum byte.
module tx_chunk_framer
  import tx_chunk_pkg::*;
#(
  parameter int PAYLOAD_BYTES = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       chunk_valid,
  input  logic [7:0]                 chunk_type,
  input  logic [PAYLOAD_BYTES*8-1:0] chunk_bytes,
  output logic                       chunk_ack,
  output logic [7:0]                 tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy
);

  localparam int IDX_W = $clog2(PAYLOAD_BYTES + 2);
`ifdef TX_CHUNK_CHECKSUM_EN
  localparam int LAST_INT = PAYLOAD_BYTES + 1;
`else
  localparam int LAST_INT = PAYLOAD_BYTES;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAST_INT);

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [7:0]                 type_q, type_d;
  logic [PAYLOAD_BYTES*8-1:0] payload_q, payload_d;
`ifdef TX_CHUNK_CHECKSUM_EN
  logic [7:0]                 csum_q, csum_d;
`endif

  logic       capture;
  logic       accept;
  logic       last_idx;
  logic [7:0] cur_byte;

  // IDLE is the only state that samples chunk_valid, so the ACK cycle can
  // never start a duplicate frame while the producer is still dropping it.
  assign capture  = (state_q == ST_IDLE) && chunk_valid;
  assign accept   = (state_q == ST_SEND) && tx_ready;
  assign last_idx = (idx_q == LAST_IDX);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (chunk_valid) state_d = ST_SEND;
      ST_SEND: if (tx_ready && last_idx) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs, decoded from registered state and shadows only so that
  // tx_ready has no combinational path to tx_data or tx_valid.
  // ---------------------------------------------------------------------
  always_comb begin
    tx_valid  = (state_q == ST_SEND);
    chunk_ack = (state_q == ST_ACK);
    busy      = (state_q != ST_IDLE);
    tx_data   = (state_q == ST_SEND) ? cur_byte : 8'h00;
  end

  // Byte select: index 0 is the type, 1..PAYLOAD_BYTES the payload, and
  // the slot after the payload carries the running checksum when enabled.
  always_comb begin
    cur_byte = type_q;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      if (idx_q == IDX_W'(i + 1)) begin
        cur_byte = payload_q[8*i +: 8];
      end
    end
`ifdef TX_CHUNK_CHECKSUM_EN
    if (last_idx) begin
      cur_byte = csum_q;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Datapath: byte index and shadow registers
  // ---------------------------------------------------------------------
  always_comb begin
    idx_d     = idx_q;
    type_d    = type_q;
    payload_d = payload_q;
    if (capture) begin
      idx_d     = '0;
      type_d    = chunk_type;
      payload_d = chunk_bytes;
    end else if (accept && !last_idx) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q     <= '0;
      type_q    <= 8'h00;
      payload_q <= '0;
    end else begin
      idx_q     <= idx_d;
      type_q    <= type_d;
      payload_q <= payload_d;
    end
  end

`ifdef TX_CHUNK_CHECKSUM_EN
  // The accumulator folds in every accepted data byte; by the time the
  // index reaches the checksum slot it holds type ^ all payload bytes.
  always_comb begin
    csum_d = csum_q;
    if (capture) begin
      csum_d = CSUM_SEED;
    end else if (accept && !last_idx) begin
      csum_d = csum_step(csum_q, cur_byte);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      csum_q <= 8'h00;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

endmodule

// File: tb/tb_tx_chunk_framer.sv
module tb_tx_chunk_framer;

  localparam int PB = 2;
`ifdef TX_CHUNK_CHECKSUM_EN
  localparam int NB = PB + 2;
`else
  localparam int NB = PB + 1;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        chunk_valid = 1'b0;
  logic [7:0]  chunk_type = 8'h00;
  logic [15:0] chunk_bytes = 16'h0000;
  logic        tx_ready = 1'b1;
  logic        chunk_ack;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        busy;

  tx_chunk_framer #(.PAYLOAD_BYTES(PB)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .chunk_valid (chunk_valid),
    .chunk_type  (chunk_type),
    .chunk_bytes (chunk_bytes),
    .chunk_ack   (chunk_ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // tx_ready driver: 0 = always ready, 1 = stall window, 2 = random
  int rdy_mode = 0;
  int stall_lo = 0;
  int stall_hi = -1;
  always @(posedge CLK) begin
    #1;
    case (rdy_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Reference model: the frame in flight is a queue of the bytes still to
  // go; once it drains, one ack cycle follows; a new frame is taken only
  // when nothing is in flight and no ack is pending.
  logic [7:0] mq[$];
  bit         m_ack = 1'b0;
`ifdef TX_CHUNK_CHECKSUM_EN
  logic [7:0] m_x;
`endif
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mq.delete();
      m_ack = 1'b0;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (mq.size() > 0) begin
      if (tx_ready) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_ack = 1'b1;
      end
    end else if (chunk_valid) begin
      mq.push_back(chunk_type);
      for (int i = 0; i < PB; i++) mq.push_back(chunk_bytes[8*i +: 8]);
`ifdef TX_CHUNK_CHECKSUM_EN
      m_x = chunk_type;
      for (int i = 0; i < PB; i++) m_x = m_x ^ chunk_bytes[8*i +: 8];
      mq.push_back(m_x);
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    check("m_valid", {31'd0, tx_valid}, {31'd0, (mq.size() > 0)});
    check("m_ack", {31'd0, chunk_ack}, {31'd0, m_ack});
    check("m_busy", {31'd0, busy}, {31'd0, ((mq.size() > 0) || m_ack)});
    if (mq.size() > 0) check("m_data", {24'd0, tx_data}, {24'd0, mq[0]});
  end

  // Monitor: accepted bytes with their cycle, and acks.
  logic [7:0] acc_b[$];
  int         acc_c[$];
  int         ack_cnt = 0;
  always @(negedge CLK) begin
    if (RST_N) begin
      if (tx_valid && tx_ready) begin
        acc_b.push_back(tx_data);
        acc_c.push_back(cyc);
      end
      if (chunk_ack) ack_cnt++;
    end
  end

  task automatic clear_mon();
    acc_b.delete();
    acc_c.delete();
    ack_cnt = 0;
  endtask

  // Producer: present a chunk, hold it until ack, drop it the cycle after.
  // Called #1 after a rising edge with the framer idle; returns likewise.
  task automatic produce(input logic [7:0] ty, input logic [15:0] pl, input bit late,
                         input logic [15:0] late_pl, output int c0, output int a_cyc);
    int n;
    chunk_type  = ty;
    chunk_bytes = pl;
    chunk_valid = 1'b1;
    c0 = cyc;
    if (late) begin
      @(posedge CLK); #1;
      chunk_bytes = late_pl;
      chunk_type  = 8'($urandom);
    end
    n = 0;
    while (n < 400) begin
      @(negedge CLK);
      if (chunk_ack) break;
      n++;
    end
    check("ack_within_budget", {31'd0, chunk_ack}, 32'd1);
    check("no_valid_in_ack", {31'd0, tx_valid}, 32'd0);
    a_cyc = cyc;
    @(posedge CLK); #1;
    chunk_valid = 1'b0;
  endtask

  // Literal frame check: e holds the expected bytes (byte i at e[8i+:8]).
  task automatic check_frame(input string tag, input logic [31:0] e, input int c0,
                             input int stall, input int a_cyc);
    check({tag, "_len"}, acc_b.size(), NB);
    for (int i = 0; i < NB; i++) begin
      if (i < acc_b.size()) begin
        check({tag, "_byte"}, {24'd0, acc_b[i]}, {24'd0, e[8*i +: 8]});
        check({tag, "_cyc"}, acc_c[i], c0 + 1 + i + ((i > 0) ? stall : 0));
      end
    end
    check({tag, "_ack_cyc"}, a_cyc, c0 + 1 + NB + stall);
    check({tag, "_ack_cnt"}, ack_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, ac;
    logic [7:0]  rt;
    logic [15:0] rp;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_chunk_ack", {31'd0, chunk_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (2) begin @(posedge CLK); #1; end

    // 1: basic frame, always ready
    clear_mon();
    produce(8'h06, 16'h5A03, 1'b0, 16'h0000, c0, ac);
    repeat (3) begin @(posedge CLK); #1; end
    check_frame("basic", 32'h5F5A0306, c0, 0, ac);

    // 2: three stalled cycles on the second byte
    clear_mon();
    stall_lo = cyc + 2;
    stall_hi = cyc + 4;
    rdy_mode = 1;
    produce(8'h06, 16'h5A03, 1'b0, 16'h0000, c0, ac);
    repeat (3) begin @(posedge CLK); #1; end
    rdy_mode = 0;
    check_frame("stall", 32'h5F5A0306, c0, 3, ac);

    // 3: payload changes after capture
    clear_mon();
    produce(8'h06, 16'h5A03, 1'b1, 16'hFFFF, c0, ac);
    repeat (3) begin @(posedge CLK); #1; end
    check_frame("late_change", 32'h5F5A0306, c0, 0, ac);

    // 4: reset after the type byte, then full resend
    clear_mon();
    chunk_type  = 8'h06;
    chunk_bytes = 16'h5A03;
    chunk_valid = 1'b1;
    @(posedge CLK);               // capture
    @(posedge CLK);               // type byte accepted
    #2 RST_N = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_first", {24'd0, (acc_b.size() > 0) ? acc_b[0] : 8'h00}, 32'h06);
    check("rst_mid_count", acc_b.size(), 1);
    @(posedge CLK); #2;
    RST_N = 1'b1;
    check("rst_mid_no_ack", ack_cnt, 0);
    clear_mon();
    produce(8'h06, 16'h5A03, 1'b0, 16'h0000, c0, ac);
    repeat (3) begin @(posedge CLK); #1; end
    check_frame("after_reset", 32'h5F5A0306, c0, 0, ac);

    // 5: back-to-back, request reasserted two cycles after the ack
    clear_mon();
    produce(8'h06, 16'h5A03, 1'b0, 16'h0000, c0, ac);
    clear_mon();
    @(posedge CLK); #1;
    check("b2b_gap", cyc, ac + 2);
    produce(8'h06, 16'h1104, 1'b0, 16'h0000, c0, ac);
    repeat (3) begin @(posedge CLK); #1; end
    check_frame("b2b", 32'h13110406, c0, 0, ac);

    // 6: randomized frames, random backpressure, random late changes
    rdy_mode = 2;
    for (int f = 0; f < 150; f++) begin
      rt = 8'($urandom);
      rp = 16'($urandom);
      produce(rt, rp, 1'($urandom_range(0, 1)), 16'($urandom), c0, ac);
      repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
    end
    rdy_mode = 0;
    repeat (5) begin @(posedge CLK); #1; end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
